rvx_bus_arbiter: RTL
====================

// Module: rvx_bus_arbiter
// PURPOSE
//  Two-manager arbiter sharing one rvx_bus manager port between the rvx_core data bus (M0)
//  and a second manager such as a DMA engine (M1). Sits between the managers and rvx_bus.
//  Only one transaction is outstanding at a time. Round-robin or fixed-priority grant.
//  A per-transaction timeout keeps an unresponsive device from hanging the bus.
// PARAMETERS
//  FIXED_PRIORITY  0    1: M0 always wins conflicts; 0: round-robin
//  TIMEOUT_CYCLES  255  wait-cycle limit in BUSY; 0 disables the timeout; range 0..65535
// PORTS
//  clock              in   1   system clock
//  reset_n            in   1   asynchronous active-low reset
//  mN_rw_address      in   32  manager N address (N=0,1)
//  mN_write_data      in   32  manager N write data
//  mN_write_strobe    in   4   manager N byte strobes
//  mN_read_request    in   1   manager N read request; level, held until response
//  mN_write_request   in   1   manager N write request; level, held until response
//  mN_read_data       out  32  read data to manager N; valid with mN_read_response
//  mN_read_response   out  1   one-cycle read completion pulse
//  mN_write_response  out  1   one-cycle write completion pulse
//  s_rw_address       out  32  to rvx_bus manager_rw_address (registered)
//  s_write_data       out  32  registered write data
//  s_write_strobe     out  4   registered strobes
//  s_read_request     out  1   held high until s_read_response or timeout
//  s_write_request    out  1   held high until s_write_response or timeout
//  s_read_data        in   32  from rvx_bus
//  s_read_response    in   1   from rvx_bus
//  s_write_response   in   1   from rvx_bus
//  bus_error          out  1   one-cycle pulse when a timeout completes a transaction
// BEHAVIOUR
//  Reset values: all s_* outputs 0, all responses 0, mN_read_data 0, bus_error 0.
//  Reset also sets state IDLE, last_grant=1 (M0 wins the first conflict) and timer=0.
//  Reset asserted mid-transaction aborts it: no response is issued and the request drops immediately.
//  FSM: IDLE -> BUSY on any request. BUSY -> IDLE on an s response or on timeout.
//  IDLE arbitration:
//   - single requester wins
//   - both requesting: FIXED_PRIORITY=1 picks M0; otherwise the manager != last_grant wins
//   - on the grant edge: register address, data, strobe and kind; set grant and last_grant; timer=0
//  Same manager raising read and write together: write is served, read stays pending.
//  BUSY:
//   - s_*_request matches the latched kind
//   - timer counts 1 per cycle and saturates
//   - mN_* inputs are ignored, so a manager may change them only after its response
//  Completion on an s response of the matching kind:
//   - granted manager gets its response pulse in the same cycle
//   - mN_read_data = s_read_data in that cycle (combinational); otherwise holds its last value
//   - s request deasserts on the next edge; back to IDLE
//  Latency: request seen in IDLE at cycle t; s request high at t+1.
//   A same-cycle device response at t+1 gives a manager response at t+1 (one cycle of arbiter overhead).
//  Timeout: when timer == TIMEOUT_CYCLES-1 with no response:
//   - granted manager gets a response pulse with read_data = 0, plus a bus_error pulse
//   - s request drops; back to IDLE
//  A late s response arriving in IDLE is ignored.
//  Response of the wrong kind (s_write_response during a read): ignored, keep waiting.
//  Managers must drop requests the cycle after a response.
//   An arbiter in IDLE sees the next request earliest 1 cycle after a completion.
//   Back-to-back requests from one manager therefore cost 1 IDLE cycle.
//  Ungranted manager: response outputs 0, read_data unchanged.
// STRUCTURE
//  Shared package rvx_pkg: arbiter state encodings (IDLE/BUSY) and RVX_BUS_ERROR_DATA = 32'h0.
//  One sub-module, rvx_rr_arbiter2: 2-way round-robin/fixed grant.
//   - inputs: req[1:0], last_grant, fixed
//   - output: one-hot grant; combinational
//  FSM, timer and datapath registers stay in this module.
// TESTING
//  M0 read 0x100, device responds 2 cycles later with 0xCAFEF00D
//   -> s_read_request high for 3 cycles; m0_read_response pulse with 0xCAFEF00D; m1 quiet
//  M0 and M1 write in the same cycle, FIXED_PRIORITY=0, after reset
//   -> M0 served first; M1 gets s_write_request right after the M0 completion cycle plus 1 IDLE
//  Continuous M0+M1 reads for 6 transactions, round-robin
//   -> grants alternate M0,M1,M0,...
//  Same continuous M0+M1 reads with FIXED_PRIORITY=1 -> M1 never granted while M0 re-requests
//  TIMEOUT_CYCLES=4, M1 read with no response
//   -> s_read_request high 4 cycles; m1_read_response with data 0 and bus_error pulse
//   -> a device response 2 cycles later is ignored
//  reset_n low during BUSY
//   -> all outputs 0 immediately; after release a pending M1 request is granted normally

Source files
------------

// File: rtl/rvx_pkg.sv
// Shared rvx types and constants.
// Used by the bus arbiter and its grant helper.
package rvx_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam logic [31:0] RVX_BUS_ERROR_DATA = 32'h0;

endpackage

// File: rtl/rvx_rr_arbiter2.sv
// Two-way grant: a lone requester wins; on a conflict
// fixed mode favours M0, otherwise the one not granted last.
module rvx_rr_arbiter2
    import rvx_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       fixed,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (fixed || last_grant) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/rvx_bus_arbiter.sv
// Shares one rvx_bus manager port between the core (M0) and a
// second manager (M1); one transaction in flight, with timeout.
module rvx_bus_arbiter
    import rvx_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] m0_rw_address,
    input  logic [31:0] m0_write_data,
    input  logic [3:0]  m0_write_strobe,
    input  logic        m0_read_request,
    input  logic        m0_write_request,
    output logic [31:0] m0_read_data,
    output logic        m0_read_response,
    output logic        m0_write_response,
    input  logic [31:0] m1_rw_address,
    input  logic [31:0] m1_write_data,
    input  logic [3:0]  m1_write_strobe,
    input  logic        m1_read_request,
    input  logic        m1_write_request,
    output logic [31:0] m1_read_data,
    output logic        m1_read_response,
    output logic        m1_write_response,
    output logic [31:0] s_rw_address,
    output logic [31:0] s_write_data,
    output logic [3:0]  s_write_strobe,
    output logic        s_read_request,
    output logic        s_write_request,
    input  logic [31:0] s_read_data,
    input  logic        s_read_response,
    input  logic        s_write_response,
    output logic        bus_error
);

    localparam logic        TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic        FIXED   = (FIXED_PRIORITY != 0);

    arb_state_t  state;
    logic        gnt;
    logic        kind_wr;
    logic        last_grant;
    logic [15:0] timer;
    logic [31:0] m0_rd_q;
    logic [31:0] m1_rd_q;

    logic [1:0]  req;
    logic [1:0]  grant;
    logic        wr_sel;
    logic        busy;
    logic        hit_ok;
    logic        hit_to;
    logic        done;
    logic [31:0] rd_val;

    assign req[0] = m0_read_request | m0_write_request;
    assign req[1] = m1_read_request | m1_write_request;

    rvx_rr_arbiter2 u_rr (
        .req        (req),
        .last_grant (last_grant),
        .fixed      (FIXED),
        .grant      (grant)
    );

    // A write wins over a read raised together by the same manager.
    assign wr_sel = grant[1] ? m1_write_request : m0_write_request;

    assign busy   = (state == ARB_BUSY);
    assign hit_ok = busy && (kind_wr ? s_write_response : s_read_response);
    assign hit_to = busy && !hit_ok && TO_EN && (timer == TO_LAST);
    assign done   = hit_ok || hit_to;
    assign rd_val = hit_ok ? s_read_data : RVX_BUS_ERROR_DATA;

    assign m0_read_response  = done && !kind_wr && !gnt;
    assign m1_read_response  = done && !kind_wr && gnt;
    assign m0_write_response = done && kind_wr && !gnt;
    assign m1_write_response = done && kind_wr && gnt;
    assign m0_read_data      = m0_read_response ? rd_val : m0_rd_q;
    assign m1_read_data      = m1_read_response ? rd_val : m1_rd_q;
    assign bus_error         = hit_to;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ARB_IDLE;
            gnt             <= 1'b0;
            kind_wr         <= 1'b0;
            last_grant      <= 1'b1;
            timer           <= '0;
            s_rw_address    <= '0;
            s_write_data    <= '0;
            s_write_strobe  <= '0;
            s_read_request  <= 1'b0;
            s_write_request <= 1'b0;
            m0_rd_q         <= '0;
            m1_rd_q         <= '0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (|req) begin
                        state           <= ARB_BUSY;
                        gnt             <= grant[1];
                        last_grant      <= grant[1];
                        timer           <= '0;
                        kind_wr         <= wr_sel;
                        s_write_request <= wr_sel;
                        s_read_request  <= !wr_sel;
                        s_rw_address    <= grant[1] ? m1_rw_address : m0_rw_address;
                        s_write_data    <= grant[1] ? m1_write_data : m0_write_data;
                        s_write_strobe  <= grant[1] ? m1_write_strobe : m0_write_strobe;
                    end
                end
                ARB_BUSY: begin
                    if (timer != 16'hFFFF) begin
                        timer <= timer + 16'd1;
                    end
                    if (done) begin
                        state           <= ARB_IDLE;
                        s_read_request  <= 1'b0;
                        s_write_request <= 1'b0;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
            if (m0_read_response) begin
                m0_rd_q <= rd_val;
            end
            if (m1_read_response) begin
                m1_rd_q <= rd_val;
            end
        end
    end

endmodule
